// File: rtl/formula_n_pipe_aware_fsm.sv
// Sum of isqrt over N_ARGS operands using one external pipelined isqrt unit.
// Operands are issued back-to-back; results are accumulated in return order.
module formula_n_pipe_aware_fsm #(
  parameter int N_ARGS = 3,
  parameter int ARG_W  = 32,
  parameter int RES_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arg_vld,
  output logic                    arg_rdy,
  input  logic [N_ARGS*ARG_W-1:0] args,
  output logic                    res_vld,
  output logic [RES_W-1:0]        res,
  output logic                    isqrt_x_vld,
  output logic [ARG_W-1:0]        isqrt_x,
  input  logic                    isqrt_y_vld,
  input  logic [ARG_W/2-1:0]      isqrt_y,
  output logic                    spurious
);

  localparam int YW = ARG_W / 2;
  localparam int CW = $clog2(N_ARGS + 1);
  localparam int SW = (RES_W > YW) ? RES_W : YW;

  localparam logic [CW-1:0] N_C  = CW'(N_ARGS);
  localparam logic [CW-1:0] LAST = CW'(N_ARGS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state;
  logic [CW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [RES_W-1:0]        acc;
  logic [N_ARGS*ARG_W-1:0] sh;

  logic [SW-1:0]    sum_w;
  logic [RES_W-1:0] sum;
  logic             busy;
  logic             ret;
  logic             last_ret;

  always_comb begin
    sum_w    = SW'(acc) + SW'(isqrt_y);
    sum      = sum_w[RES_W-1:0];
    busy     = (state == ISSUE) || (state == DRAIN);
    ret      = busy && isqrt_y_vld;
    last_ret = ret && (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      acc         <= '0;
      sh          <= '0;
      arg_rdy     <= 1'b1;
      res_vld     <= 1'b0;
      res         <= '0;
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      spurious    <= 1'b0;
    end else begin
      if (ret) begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
      // Returns with nothing in flight are dropped but remembered
      if (isqrt_y_vld && !busy)
        spurious <= 1'b1;
      unique case (state)
        IDLE: begin
          if (arg_vld) begin
            sh          <= args >> ARG_W;
            isqrt_x     <= args[ARG_W-1:0];
            isqrt_x_vld <= 1'b1;
            idx         <= CW'(1);
            acc         <= '0;
            cnt         <= '0;
            arg_rdy     <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx == N_C) begin
            isqrt_x_vld <= 1'b0;
            state       <= DRAIN;
          end else begin
            isqrt_x <= sh[ARG_W-1:0];
            sh      <= sh >> ARG_W;
            idx     <= idx + CW'(1);
          end
          if (last_ret) begin
            isqrt_x_vld <= 1'b0;
            res         <= sum;
            res_vld     <= 1'b1;
            state       <= DONE;
          end
        end
        DRAIN: begin
          if (last_ret) begin
            res     <= sum;
            res_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          res_vld <= 1'b0;
          arg_rdy <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/formula_n_pipe_aware_fsm.md
Name: formula_n_pipe_aware_fsm

Overview:
Computes res = isqrt(x0) + isqrt(x1) + ... + isqrt(x[N_ARGS-1]) using one external pipelined isqrt unit. Once it accepts an argument set, it issues all arguments to the isqrt pipe back-to-back, one per cycle, so the pipe stays full. It accumulates results as they return and presents the sum as a single-cycle pulse. It replaces the fixed 3-argument, one-in-flight formula FSM with a version parametrised in argument count and width.

Parameters:
N_ARGS, 3, number of arguments per set; legal range 1..16.
ARG_W, 32, width of each argument and of isqrt_x; must be even.
RES_W, 32, width of res; the sum wraps modulo 2^RES_W.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
arg_vld  input  1  argument set valid.
arg_rdy  output  1  block can accept a set.
args  input  N_ARGS*ARG_W  packed arguments; x[i] = args[i*ARG_W +: ARG_W].
res_vld  output  1  result pulse.
res  output  RES_W  sum of square roots.
isqrt_x_vld  output  1  request to the isqrt pipe.
isqrt_x  output  ARG_W  isqrt operand.
isqrt_y_vld  input  1  isqrt result valid; results return in issue order.
isqrt_y  input  ARG_W/2  isqrt result.
spurious  output  1  sticky flag: isqrt_y_vld arrived with nothing outstanding.

Behaviour:
- All outputs are registered. Reset values: arg_rdy=1, res_vld=0, res=0, isqrt_x_vld=0, isqrt_x=0, spurious=0. The internal issue index, return count and accumulator reset to 0.
- States:
  - IDLE: arg_rdy=1.
  - ISSUE: operands are being sent.
  - DRAIN: all operands sent, results still outstanding.
  - DONE: one cycle, res_vld=1.
- IDLE -> ISSUE when arg_vld && arg_rdy is sampled at edge T. On that edge:
  - all N_ARGS arguments are latched;
  - the accumulator and return count are cleared;
  - arg_rdy drops to 0.
- ISSUE: during cycles T+1 .. T+N_ARGS, isqrt_x_vld=1 and isqrt_x=x[k] in cycle T+1+k. There are no gaps and no backpressure. Transition:
  - after the last issue, go to DRAIN;
  - go directly to DONE if the final return is sampled on the same edge.
- Return handling is active in ISSUE and DRAIN. On each sampled isqrt_y_vld:
  - acc <= acc + zero_extend(isqrt_y), truncated to RES_W;
  - count <= count + 1.
- Returns can overlap issue when isqrt latency < N_ARGS. Issue and accumulate in the same cycle are both required to work.
- When the N_ARGS-th return is sampled at edge E:
  - at E: res <= final sum, res_vld <= 1, state goes to DONE;
  - at E+1: res_vld <= 0, arg_rdy <= 1, state goes to IDLE.
- res holds its value until the next completion.
- arg_vld while arg_rdy=0 is ignored. No set is queued and the args input is not sampled.
- An isqrt_y_vld sampled in IDLE or DONE is discarded (no accumulation) and sets spurious=1. spurious clears only on reset.
- Reset mid-operation: the set in progress is abandoned and no res_vld pulse is produced. Results still in the isqrt pipe that arrive after reset set spurious.
- Total latency from accept to res_vld = max(N_ARGS, L + N_ARGS - 1) + 1 cycles, where L is the isqrt pipe latency counted from issue to return.
- Throughput: one set per (latency + 2) cycles. A new set is never accepted in the same cycle as res_vld.

Test Plan:
- Reset check: hold rst=0 -> all outputs read 0 except arg_rdy=1. Release rst -> state is IDLE.
- Basic set: N_ARGS=3, args={4,9,16}, isqrt model L=4 -> isqrt_x reads 4, 9, 16 in three consecutive cycles; a single res_vld pulse with res=9; arg_rdy returns to 1 one cycle after the pulse.
- Generalisation: N_ARGS=8 with all args = 0xFFFFFFFF, and RES_W=16 -> each isqrt_y=65535; res = (8*65535) mod 2^16 = 65528 (wrap check). Repeat with L=1 so returns overlap issue; res must be unchanged.
- Busy rejection: assert arg_vld with args={1,1,1} while in ISSUE or DRAIN -> the input is ignored; the current set still yields res=9; no second res_vld pulse.
- Spurious return: pulse isqrt_y_vld=1 with isqrt_y=7 while in IDLE -> spurious=1 and stays 1; the next set {0,1,4} gives res=3, so the stray value was not accumulated.
- Reset mid-drain: assert rst=0 after two of three returns -> res_vld is never asserted; the late third return sets spurious; the next set {25,36,49} gives res=18.
